sync_fifo_ctrl: RTL and testbench

- Single-clock, parametrised successor to the team's dual-clock FIFO, for buffers whose producer and consumer share one clock.
- No Gray-code pointers and no synchronisers. An occupancy counter drives exact full/empty flags.
- Adds programmable almost-full/almost-empty thresholds, a fill-level output, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.

---
 rtl/sync_fifo_pkg.sv | 30 +++
 rtl/sync_fifo_if.sv | 27 ++
 rtl/fifomem.sv | 22 ++
 rtl/sync_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  // Occupancy needs one bit more than the address to represent DEPTH itself.
  function automatic int count_width(input int asize);
    return asize + 1;
  endfunction

  localparam int DEF_DEPTH = depth_of(DEF_ASIZE);

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
interface sync_fifo_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) ();
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifomem.sv
// FIFO storage array: gated synchronous write, combinational read.
module fifomem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int DEPTH    = 1 << ADDRSIZE
) (
  input  logic                wclk,
  input  logic                wclken,
  input  logic                wfull,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] wdata,
  output logic [DATASIZE-1:0] rdata
);
  logic [DATASIZE-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  always_ff @(posedge wclk) begin
    if (wclken && !wfull) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary pointers, occupancy count, registered
// flags, sticky error flags and a selectable standard / first-word-fall-through read.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave fifo
);
  localparam int DEPTH = depth_of(ASIZE);

  typedef logic [count_width(ASIZE)-1:0] count_t;

  localparam count_t DEPTH_C  = count_t'(DEPTH);
  localparam count_t AFULL_C  = count_t'(AFULL_TH);
  localparam count_t AEMPTY_C = count_t'(AEMPTY_TH);

  if (ASIZE < 1) begin : g_chk_asize
    $error("sync_fifo_ctrl: ASIZE must be at least 1");
  end
  if (AEMPTY_TH >= AFULL_TH) begin : g_chk_th_order
    $error("sync_fifo_ctrl: AEMPTY_TH must be below AFULL_TH");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
    $error("sync_fifo_ctrl: AFULL_TH outside 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
    $error("sync_fifo_ctrl: AEMPTY_TH outside 0..DEPTH-1");
  end
  if (count_width(ASIZE) != clog2(DEPTH + 1)) begin : g_chk_cnt_w
    $error("sync_fifo_ctrl: count width cannot hold DEPTH");
  end

  logic [ASIZE-1:0] waddr, raddr;
  count_t           count_q, count_next;
  logic             wfull_q, walmost_full_q, rempty_q, ralmost_empty_q;
  logic             overflow_q, underflow_q;
  logic             we, re;
  logic [DSIZE-1:0] mem_rdata;

  // Flags gate strictly: a same-cycle read never frees space for a write when full.
  assign we         = fifo.winc & ~wfull_q;
  assign re         = fifo.rinc & ~rempty_q;
  assign count_next = count_q + count_t'(we) - count_t'(re);

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr           <= '0;
      raddr           <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      walmost_full_q  <= 1'b0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      if (we) waddr <= waddr + 1'b1;
      if (re) raddr <= raddr + 1'b1;
      count_q         <= count_next;
      wfull_q         <= (count_next == DEPTH_C);
      walmost_full_q  <= (count_next >= AFULL_C);
      rempty_q        <= (count_next == '0);
      ralmost_empty_q <= (count_next <= AEMPTY_C);
      overflow_q      <= overflow_q | (fifo.winc & wfull_q);
      underflow_q     <= underflow_q | (fifo.rinc & rempty_q);
    end
  end

  fifomem #(
    .DATASIZE(DSIZE),
    .ADDRSIZE(ASIZE),
    .DEPTH   (DEPTH)
  ) u_mem (
    .wclk  (clk),
    .wclken(fifo.winc),
    .wfull (wfull_q),
    .waddr (waddr),
    .raddr (raddr),
    .wdata (fifo.wdata),
    .rdata (mem_rdata)
  );

  if (FWFT == int'(FIFO_FWFT)) begin : g_fwft
    assign fifo.rdata = mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem_rdata;
    end
    assign fifo.rdata = rdata_q;
  end

  assign fifo.count         = count_q;
  assign fifo.wfull         = wfull_q;
  assign fifo.walmost_full  = walmost_full_q;
  assign fifo.rempty        = rempty_q;
  assign fifo.ralmost_empty = ralmost_empty_q;
  assign fifo.overflow      = overflow_q;
  assign fifo.underflow     = underflow_q;

  a_count_range : assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: standard and FWFT instances share one stimulus
// stream and are compared against a queue-based model of the FIFO.
module tb_sync_fifo_ctrl;
  localparam int DSIZE = 8;
  localparam int ASIZE = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int AEMPTY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if_std ();
  sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) if_fw ();

  sync_fifo_ctrl #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(0)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .fifo(if_std.slave)
  );

  sync_fifo_ctrl #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(1)
  ) u_fw (
    .clk (clk),
    .rst (rst),
    .fifo(if_fw.slave)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  logic [DSIZE-1:0] q[$];
  bit               ovf, unf;
  logic [DSIZE-1:0] exp_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit w, input logic [DSIZE-1:0] d, input bit rd);
    bit full, empty;
    if (r) begin
      q.delete();
      ovf    = 0;
      unf    = 0;
      exp_rd = '0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (rd && !empty) exp_rd = q.pop_front();
      if (w && !full) q.push_back(d);
      if (w && full) ovf = 1;
      if (rd && empty) unf = 1;
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check_val("std.count", 32'(if_std.count), n);
    check_val("std.wfull", 32'(if_std.wfull), 32'(n == DEPTH));
    check_val("std.walmost_full", 32'(if_std.walmost_full), 32'(n >= AFULL));
    check_val("std.rempty", 32'(if_std.rempty), 32'(n == 0));
    check_val("std.ralmost_empty", 32'(if_std.ralmost_empty), 32'(n <= AEMPTY));
    check_val("std.overflow", 32'(if_std.overflow), 32'(ovf));
    check_val("std.underflow", 32'(if_std.underflow), 32'(unf));
    check_val("std.rdata", 32'(if_std.rdata), 32'(exp_rd));
    check_val("fw.count", 32'(if_fw.count), n);
    check_val("fw.rempty", 32'(if_fw.rempty), 32'(n == 0));
    check_val("fw.overflow", 32'(if_fw.overflow), 32'(ovf));
    check_val("fw.underflow", 32'(if_fw.underflow), 32'(unf));
    if (n != 0) check_val("fw.rdata", 32'(if_fw.rdata), 32'(q[0]));
  endtask

  task automatic step(input bit r, input bit w, input logic [DSIZE-1:0] d, input bit rd);
    @(negedge clk);
    rst          = r;
    if_std.winc  = w;
    if_fw.winc   = w;
    if_std.wdata = d;
    if_fw.wdata  = d;
    if_std.rinc  = rd;
    if_fw.rinc   = rd;
    @(posedge clk);
    model_update(r, w, d, rd);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 1, 8'hEE, 1);
  endtask

  initial begin
    logic [DSIZE-1:0] pat;
    if_std.winc = 0; if_fw.winc = 0;
    if_std.rinc = 0; if_fw.rinc = 0;
    if_std.wdata = '0; if_fw.wdata = '0;

    phase = "reset";
    do_reset();

    phase = "fill";
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h10 + i), 0);

    phase = "drain";
    for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 1);

    phase = "simul_empty";
    do_reset();
    step(0, 1, 8'h30, 1);

    phase = "simul_full";
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h40 + i), 0);
    step(0, 1, 8'h99, 1);

    phase = "simul_mid";
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(0, 1, 8'h77, 1);

    phase = "wrap";
    do_reset();
    pat = 8'hA0;
    for (int g = 0; g < 20; g++) begin
      for (int i = 0; i < 3; i++) begin
        step(0, 1, pat, 0);
        pat = pat + 8'd1;
      end
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    end

    phase = "fwft";
    do_reset();
    step(0, 1, 8'h55, 0);
    step(0, 0, 8'h00, 1);

    phase = "random";
    do_reset();
    for (int p = 0; p < 3; p++) begin
      int pw;
      pw = (p == 0) ? 80 : (p == 1) ? 50 : 20;
      for (int i = 0; i < 150; i++) begin
        step(($urandom_range(0, 59) == 0),
             ($urandom_range(0, 99) < pw),
             8'($urandom),
             ($urandom_range(0, 99) < (100 - pw)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
